// File: rtl/led_seq_pkg.sv
// Shared encodings and LFSR helper for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PP   = 2'b10,
        MODE_RAND = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned LFSR_W = 8;

    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/led_seq_ctrl_sync2.sv
// Two-flop synchronizer for a bundle of asynchronous switch inputs.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk1h,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture into the clk1h domain.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Mode-selectable index sequencer feeding the 3-to-8 LED decoder.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned       IDX_W     = 3,
    parameter int unsigned       DWELL_W   = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01
) (
    input  logic               clk1h,
    input  logic               rst,
    input  logic               run,
    input  logic               clr,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [IDX_W-1:0]   idx,
    output logic               dir,
    output logic               wrap,
    output logic               active
);

    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    logic [3:0]         sync_q;
    logic               run_s;
    logic               clr_s;
    mode_e              mode_s;
    mode_e              mode_d;

    state_e             state_q;
    state_e             state_nxt;

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;

    logic [IDX_W-1:0]   idx_q;
    logic               dir_q;
    logic               wrap_q;
    logic               active_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [IDX_W-1:0]   rcnt_q;

    logic               adv_c;
    logic               step_c;
    logic               start_c;
    logic               rand_enter_c;
    logic               pp_down_c;
    logic [IDX_W-1:0]   rcnt_base_c;
    logic [IDX_W-1:0]   idx_nxt;
    logic               dir_nxt;
    logic               wrap_nxt;
    logic [LFSR_W-1:0]  lfsr_nxt;
    logic [IDX_W-1:0]   rcnt_nxt;

    sync2 #(.W(4)) u_sync (
        .clk1h (clk1h),
        .rst   (rst),
        .d     ({mode, clr, run}),
        .q     (sync_q)
    );

    assign run_s  = sync_q[0];
    assign clr_s  = sync_q[1];
    assign mode_s = mode_e'(sync_q[3:2]);

    // State register.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; clear overrides everything and pins the FSM in IDLE.
    always_comb begin
        state_nxt = state_q;
        if (clr_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (run_s)  state_nxt = ST_RUN;
                ST_RUN:  if (!run_s) state_nxt = ST_HOLD;
                ST_HOLD: if (run_s)  state_nxt = ST_RUN;
                default:             state_nxt = ST_IDLE;
            endcase
        end
    end

    assign adv_c        = (state_q == ST_RUN) && run_s && !clr_s;
    assign step_c       = adv_c && (cnt_q == dwell_q);
    assign start_c      = (state_q == ST_IDLE) && (state_nxt == ST_RUN);
    assign rand_enter_c = (mode_s == MODE_RAND) && (mode_d != MODE_RAND);

    // Dwell counter; dwell is latched at run start and at each step boundary.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            dwell_q <= '0;
        end else if (clr_s) begin
            cnt_q   <= '0;
        end else if (start_c || step_c) begin
            cnt_q   <= '0;
            dwell_q <= dwell;
        end else if (adv_c) begin
            cnt_q   <= cnt_q + DWELL_W'(1);
        end
    end

    // Previous synchronized mode, used to detect entry into random mode.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            mode_d <= MODE_UP;
        end else begin
            mode_d <= mode_s;
        end
    end

    // Step datapath: next index, direction, wrap pulse and LFSR per mode.
    always_comb begin
        idx_nxt     = idx_q;
        dir_nxt     = dir_q;
        wrap_nxt    = 1'b0;
        lfsr_nxt    = lfsr_q;
        pp_down_c   = dir_q;
        rcnt_base_c = rand_enter_c ? '0 : rcnt_q;
        rcnt_nxt    = rcnt_base_c;
        if (step_c) begin
            case (mode_s)
                MODE_UP: begin
                    idx_nxt  = idx_q + IDX_W'(1);
                    dir_nxt  = 1'b0;
                    wrap_nxt = (idx_q == IDX_MAX);
                end
                MODE_DOWN: begin
                    idx_nxt  = idx_q - IDX_W'(1);
                    dir_nxt  = 1'b1;
                    wrap_nxt = (idx_q == '0);
                end
                MODE_PP: begin
                    // Turn around if already parked at an end facing outward.
                    if (dir_q ? (idx_q == '0) : (idx_q == IDX_MAX)) begin
                        pp_down_c = ~dir_q;
                    end
                    idx_nxt = pp_down_c ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                    dir_nxt = pp_down_c;
                    if ((idx_nxt == IDX_MAX) || (idx_nxt == '0)) begin
                        dir_nxt  = ~pp_down_c;
                        wrap_nxt = 1'b1;
                    end
                end
                MODE_RAND: begin
                    lfsr_nxt = lfsr_next(lfsr_q);
                    idx_nxt  = lfsr_nxt[IDX_W-1:0];
                    wrap_nxt = (rcnt_base_c == IDX_MAX);
                    rcnt_nxt = rcnt_base_c + IDX_W'(1);
                end
            endcase
        end
    end

    // Index, direction, wrap, LFSR and random-step counter registers.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            lfsr_q <= LFSR_SEED;
            rcnt_q <= '0;
        end else if (clr_s) begin
            idx_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            lfsr_q <= LFSR_SEED;
            rcnt_q <= '0;
        end else begin
            idx_q  <= idx_nxt;
            dir_q  <= dir_nxt;
            wrap_q <= wrap_nxt;
            lfsr_q <= lfsr_nxt;
            rcnt_q <= rcnt_nxt;
        end
    end

    // Registered RUN indicator, aligned with the state register.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= (state_nxt == ST_RUN);
        end
    end

    assign idx    = idx_q;
    assign dir    = dir_q;
    assign wrap   = wrap_q;
    assign active = active_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl.
module tb_led_seq_ctrl;

    logic       clk1h = 1'b0;
    logic       rst;
    logic       run;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] dwell;
    logic [2:0] idx;
    logic       dir;
    logic       wrap;
    logic       active;

    int errors = 0;
    int checks = 0;

    int pp_idx  [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int pp_dir  [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int pp_wrap [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    int rnd_idx [9]  = '{2, 4, 0, 1, 3, 7, 6, 4, 0};
    int rnd_wrap[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    always #5 clk1h = ~clk1h;

    led_seq_ctrl dut (
        .clk1h  (clk1h),
        .rst    (rst),
        .run    (run),
        .clr    (clr),
        .mode   (mode),
        .dwell  (dwell),
        .idx    (idx),
        .dir    (dir),
        .wrap   (wrap),
        .active (active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1h);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        run   = 1'b0;
        clr   = 1'b0;
        mode  = 2'b00;
        dwell = 4'd0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Raise run with the given mode/dwell and step through e1..e3.
    task automatic start(input logic [1:0] m, input logic [3:0] d);
        mode  = m;
        dwell = d;
        run   = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst   = 1'b0;
        run   = 1'b0;
        clr   = 1'b0;
        mode  = 2'b00;
        dwell = 4'd0;
        #3;
        check("rst idx", 32'(idx), 0);
        check("rst dir", 32'(dir), 0);
        check("rst wrap", 32'(wrap), 0);
        check("rst active", 32'(active), 0);

        // Up mode, dwell 0.
        do_reset();
        mode  = 2'b00;
        dwell = 4'd0;
        run   = 1'b1;
        tick();
        check("up e1 active", 32'(active), 0);
        tick();
        check("up e2 active", 32'(active), 0);
        tick();
        check("up e3 active", 32'(active), 1);
        check("up e3 idx", 32'(idx), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("up idx %0d", k), 32'(idx), 32'(k % 8));
            check($sformatf("up wrap %0d", k), 32'(wrap), (k == 8) ? 1 : 0);
        end
        tick();
        check("up idx after wrap", 32'(idx), 1);
        check("up wrap cleared", 32'(wrap), 0);
        check("up dir", 32'(dir), 0);

        // Ping-pong, dwell 0.
        do_reset();
        start(2'b10, 4'd0);
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("pp idx %0d", k), 32'(idx), 32'(pp_idx[k]));
            check($sformatf("pp dir %0d", k), 32'(dir), 32'(pp_dir[k]));
            check($sformatf("pp wrap %0d", k), 32'(wrap), 32'(pp_wrap[k]));
        end

        // Up mode, dwell 2, then dwell 0 mid-step.
        do_reset();
        start(2'b00, 4'd2);
        check("dw e3 idx", 32'(idx), 0);
        tick();
        check("dw e4 idx", 32'(idx), 0);
        tick();
        check("dw e5 idx", 32'(idx), 0);
        tick();
        check("dw e6 idx", 32'(idx), 1);
        dwell = 4'd0;
        tick();
        check("dw e7 idx", 32'(idx), 1);
        tick();
        check("dw e8 idx", 32'(idx), 1);
        tick();
        check("dw e9 idx", 32'(idx), 2);
        tick();
        check("dw e10 idx", 32'(idx), 3);
        tick();
        check("dw e11 idx", 32'(idx), 4);

        // Pseudo-random from reset.
        do_reset();
        start(2'b11, 4'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rnd idx %0d", k), 32'(idx), 32'(rnd_idx[k]));
            check($sformatf("rnd wrap %0d", k), 32'(wrap), 32'(rnd_wrap[k]));
        end

        // Run drop into HOLD and resume.
        do_reset();
        start(2'b00, 4'd0);
        tick();
        tick();
        tick();
        check("hold pre idx", 32'(idx), 3);
        run = 1'b0;
        tick();
        check("hold e7 idx", 32'(idx), 4);
        check("hold e7 active", 32'(active), 1);
        tick();
        check("hold e8 idx", 32'(idx), 5);
        check("hold e8 active", 32'(active), 1);
        tick();
        check("hold e9 idx", 32'(idx), 5);
        check("hold e9 active", 32'(active), 0);
        repeat (5) tick();
        check("hold long idx", 32'(idx), 5);
        check("hold long active", 32'(active), 0);
        run = 1'b1;
        tick();
        tick();
        check("resume sync active", 32'(active), 0);
        tick();
        check("resume active", 32'(active), 1);
        check("resume idx", 32'(idx), 5);
        tick();
        check("resume idx+1", 32'(idx), 6);
        tick();
        check("resume idx+2", 32'(idx), 7);

        // Clear pulse during down mode.
        do_reset();
        start(2'b01, 4'd0);
        tick();
        check("dn e4 idx", 32'(idx), 7);
        check("dn e4 dir", 32'(dir), 1);
        check("dn e4 wrap", 32'(wrap), 1);
        tick();
        tick();
        tick();
        tick();
        check("dn e8 idx", 32'(idx), 3);
        clr = 1'b1;
        tick();
        check("clr e9 idx", 32'(idx), 2);
        tick();
        check("clr e10 idx", 32'(idx), 1);
        tick();
        check("clr e11 idx", 32'(idx), 0);
        check("clr e11 dir", 32'(dir), 0);
        check("clr e11 active", 32'(active), 0);
        check("clr e11 wrap", 32'(wrap), 0);
        clr = 1'b0;
        tick();
        check("clr e12 idx", 32'(idx), 0);
        check("clr e12 active", 32'(active), 0);
        tick();
        check("clr e13 active", 32'(active), 0);
        tick();
        check("clr e14 active", 32'(active), 1);
        check("clr e14 idx", 32'(idx), 0);
        tick();
        check("clr e15 idx", 32'(idx), 7);
        check("clr e15 dir", 32'(dir), 1);
        check("clr e15 wrap", 32'(wrap), 1);

        // Asynchronous reset mid-dwell.
        do_reset();
        start(2'b01, 4'd3);
        repeat (4) tick();
        check("ar pre idx", 32'(idx), 7);
        check("ar pre wrap", 32'(wrap), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar idx", 32'(idx), 0);
        check("ar dir", 32'(dir), 0);
        check("ar wrap", 32'(wrap), 0);
        check("ar active", 32'(active), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
